// File: rtl/mdio_master.sv
// MDIO management master.
// Accepts a 32-bit management frame through a level/ack handshake. Each frame
// is sent as a 32-bit preamble of ones, then the frame MSB-first, then one idle
// MDC period. Read frames release the pad from the turnaround onward and
// capture 16 data bits on the rising edges of MDC.
module mdio_master #(
    parameter int unsigned MDC_DIV = 50   // clk cycles per MDC half-period, 2..255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] acc_data,
    input  logic        acc_en,
    output logic        acc_en_ack,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, PRE, FRAME, GAP} state_t;

    localparam logic [7:0] HALF_LAST   = 8'(MDC_DIV - 1);
    localparam logic [5:0] PRE_LAST    = 6'd31;  // last preamble bit
    localparam logic [5:0] FRAME_LAST  = 6'd63;  // frame bit 0
    localparam logic [5:0] TA_LAST_DRV = 6'd45;  // frame bit 18: last bit driven in a read
    localparam logic [5:0] RD_FIRST    = 6'd48;  // frame bit 15: first bit captured in a read

    state_t      state;
    logic [7:0]  half_cnt;   // clk cycles within the current MDC half-period
    logic [5:0]  bit_cnt;    // 0..31 preamble, 32..63 frame bits 31..0
    logic [31:0] frame_sr;   // latched frame, shifted out MSB-first
    logic [15:0] rd_sr;      // read data being assembled
    logic        rd_op;      // latched OP[1]: frame is a read
    logic        rst_done;   // first edge after reset release has completed

    assign busy = (state != IDLE);

    // Request handshake, MDC generation, bit sequencing and read capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register, including the frame shift registers, gets a reset
            // value so an aborted frame leaves nothing stale behind.
            state      <= IDLE;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            frame_sr   <= '0;
            rd_sr      <= '0;
            rd_op      <= 1'b0;
            rst_done   <= 1'b0;
            mdc        <= 1'b0;
            mdio_o     <= 1'b1;
            mdio_t     <= 1'b1;
            acc_en_ack <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every test below sees the
            // pre-edge value of the registers (e.g. mdc decides rise vs fall).
            rst_done <= 1'b1;
            rd_valid <= 1'b0;
            if (!acc_en) begin
                acc_en_ack <= 1'b0;
            end

            case (state)
                IDLE: begin
                    mdc      <= 1'b0;
                    half_cnt <= '0;
                    bit_cnt  <= '0;
                    if (acc_en && !acc_en_ack && rst_done) begin
                        acc_en_ack <= 1'b1;
                        frame_sr   <= acc_data;
                        rd_op      <= acc_data[29];
                        mdio_t     <= 1'b0;
                        mdio_o     <= 1'b1;
                        state      <= PRE;
                    end
                end

                default: begin
                    if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + 8'd1;
                    end else begin
                        half_cnt <= '0;
                        mdc      <= ~mdc;
                        if (!mdc) begin
                            // MDC rising: capture read data bits 15..0.
                            if (state == FRAME && rd_op && bit_cnt >= RD_FIRST) begin
                                rd_sr <= {rd_sr[14:0], mdio_i};
                            end
                        end else begin
                            // MDC falling: end of a bit, present the next one.
                            case (state)
                                PRE: begin
                                    bit_cnt <= bit_cnt + 6'd1;
                                    if (bit_cnt == PRE_LAST) begin
                                        state    <= FRAME;
                                        mdio_o   <= frame_sr[31];
                                        frame_sr <= {frame_sr[30:0], 1'b0};
                                    end
                                end
                                FRAME: begin
                                    if (bit_cnt == FRAME_LAST) begin
                                        state  <= GAP;
                                        mdio_t <= 1'b1;
                                        mdio_o <= 1'b1;
                                        if (rd_op) begin
                                            rd_data  <= rd_sr;
                                            rd_valid <= 1'b1;
                                        end
                                    end else begin
                                        bit_cnt  <= bit_cnt + 6'd1;
                                        mdio_o   <= frame_sr[31];
                                        frame_sr <= {frame_sr[30:0], 1'b0};
                                        mdio_t   <= rd_op && (bit_cnt >= TA_LAST_DRV);
                                    end
                                end
                                default: begin
                                    // End of the idle MDC period: mdc is falling to 0.
                                    state   <= IDLE;
                                    bit_cnt <= '0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Testbench for mdio_master: a fast instance (MDC_DIV=2) checked bit-by-bit
// against a frame model with a PHY responder, and a slow instance (MDC_DIV=50)
// checked for MDC period, duty cycle, data edge placement and busy time.
module tb_mdio_master;

    localparam int DIV        = 2;
    localparam int DIV_S      = 50;
    localparam int FRAME_CLKS = 65 * 2 * DIV;
    localparam int BOUND      = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // fast instance
    logic [31:0] acc_data;
    logic        acc_en;
    logic        acc_en_ack, mdc, mdio_o, mdio_t, rd_valid, busy;
    logic        mdio_i = 1'b1;
    logic [15:0] rd_data;

    // slow instance
    logic [31:0] acc_data_s;
    logic        acc_en_s;
    logic        acc_en_ack_s, mdc_s, mdio_o_s, mdio_t_s, rd_valid_s, busy_s;
    logic        mdio_i_s = 1'b1;
    logic [15:0] rd_data_s;

    mdio_master #(.MDC_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .acc_data(acc_data), .acc_en(acc_en),
        .acc_en_ack(acc_en_ack), .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t),
        .mdio_i(mdio_i), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
    );

    mdio_master #(.MDC_DIV(DIV_S)) dut_s (
        .clk(clk), .rst_n(rst_n), .acc_data(acc_data_s), .acc_en(acc_en_s),
        .acc_en_ack(acc_en_ack_s), .mdc(mdc_s), .mdio_o(mdio_o_s), .mdio_t(mdio_t_s),
        .mdio_i(mdio_i_s), .rd_data(rd_data_s), .rd_valid(rd_valid_s), .busy(busy_s)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- fast-instance monitor and PHY responder ----------------
    logic        obs_o[$];
    logic        obs_t[$];
    int          rv_count;
    logic [15:0] rv_data;
    logic [15:0] phy_val;
    logic        prev_mdc = 1'b0;
    int          nxt_idx;

    always @(negedge clk) begin
        if (mdc && !prev_mdc) begin
            obs_o.push_back(mdio_o);
            obs_t.push_back(mdio_t);
        end
        if (!mdc && prev_mdc) begin
            // The bit about to start is number obs_o.size() of the 65 MDC periods;
            // periods 48..63 carry frame bits 15..0 of a read.
            nxt_idx = obs_o.size();
            if (nxt_idx >= 48 && nxt_idx <= 63) mdio_i = phy_val[63 - nxt_idx];
            else                                mdio_i = 1'b1;
        end
        if (rd_valid) begin
            rv_count++;
            rv_data = rd_data;
        end
        prev_mdc = mdc;
    end

    // ---------------- slow-instance timing monitor ----------------
    int   clk_cnt_s = 0, last_edge_s = -1, min_iv = 1000000, max_iv = 0;
    int   rises_s = 0, o_bad_s = 0, busy_clks_s = 0, iv;
    logic prev_mdc_s = 1'b0, prev_o_s = 1'b1;

    always @(negedge clk) begin
        clk_cnt_s++;
        if (mdc_s !== prev_mdc_s) begin
            if (last_edge_s >= 0) begin
                iv = clk_cnt_s - last_edge_s;
                if (iv < min_iv) min_iv = iv;
                if (iv > max_iv) max_iv = iv;
            end
            last_edge_s = clk_cnt_s;
            if (mdc_s) rises_s++;
        end
        if (mdio_o_s !== prev_o_s && !(prev_mdc_s && !mdc_s)) o_bad_s++;
        if (busy_s) busy_clks_s++;
        prev_mdc_s = mdc_s;
        prev_o_s   = mdio_o_s;
    end

    // ---------------- reference model ----------------
    // Expected level of mdio_o / mdio_t at each of the 65 MDC rising edges:
    // 32 preamble ones, frame bits 31..0, then the released idle period.
    function automatic void build_exp(input logic [31:0] d,
                                      output logic [64:0] exp_o, output logic [64:0] exp_t);
        int n;
        for (int i = 0; i < 65; i++) begin
            if (i < 32) begin
                exp_o[i] = 1'b1;
                exp_t[i] = 1'b0;
            end else if (i < 64) begin
                n        = 63 - i;
                exp_o[i] = d[n];
                exp_t[i] = d[29] && (n <= 17);
            end else begin
                exp_o[i] = 1'b1;
                exp_t[i] = 1'b1;
            end
        end
    endfunction

    logic [15:0] last_rd = 16'h0;

    // One complete frame on the fast instance. hold=0: producer drops acc_en once
    // the ack has passed its two sync flops; hold>0: acc_en stays high for hold clks.
    task automatic run_frame(input string tag, input logic [31:0] d,
                             input logic [15:0] phy, input int hold);
        logic [64:0] exp_o, exp_t;
        int          cyc, drop_cyc, busy_low_cyc;
        logic        s1, s2, ob_o, ob_t;
        build_exp(d, exp_o, exp_t);
        obs_o.delete();
        obs_t.delete();
        rv_count     = 0;
        phy_val      = phy;
        cyc          = 0;
        drop_cyc     = 0;
        busy_low_cyc = 0;
        s1           = 1'b0;
        s2           = 1'b0;
        @(negedge clk);
        acc_data = d;
        acc_en   = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check({tag, "_ack_rise"}, 32'(acc_en_ack), 32'd1);
                check({tag, "_busy_rise"}, 32'(busy), 32'd1);
            end
            if (busy_low_cyc == 0 && cyc > 1 && !busy) busy_low_cyc = cyc;
            if (drop_cyc != 0 && cyc == drop_cyc + 1)
                check({tag, "_ack_drop"}, 32'(acc_en_ack), 32'd0);
            if (acc_en) begin
                if (hold == 0) begin
                    s2 = s1;
                    s1 = acc_en_ack;
                    if (s2) begin acc_en = 1'b0; drop_cyc = cyc; end
                end else if (cyc >= hold) begin
                    acc_en   = 1'b0;
                    drop_cyc = cyc;
                end
            end
        end while (cyc < BOUND && (busy_low_cyc == 0 || acc_en || cyc <= drop_cyc));
        acc_en = 1'b0;

        check({tag, "_latency"}, 32'(busy_low_cyc), 32'(FRAME_CLKS + 1));
        check({tag, "_mdc_rises"}, 32'(obs_o.size()), 32'd65);
        for (int i = 0; i < 65; i++) begin
            ob_o = (i < obs_o.size()) ? obs_o[i] : 1'bx;
            ob_t = (i < obs_t.size()) ? obs_t[i] : 1'bx;
            check($sformatf("%s_t%0d", tag, i), 32'(ob_t), 32'(exp_t[i]));
            if (!exp_t[i])
                check($sformatf("%s_o%0d", tag, i), 32'(ob_o), 32'(exp_o[i]));
        end
        if (d[29]) begin
            last_rd = phy;
            check({tag, "_rv_count"}, 32'(rv_count), 32'd1);
            check({tag, "_rv_data"}, 32'(rv_data), 32'(phy));
        end else begin
            check({tag, "_rv_count"}, 32'(rv_count), 32'd0);
        end
        check({tag, "_rd_data"}, 32'(rd_data), 32'(last_rd));
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        check({tag, "_end_mdc"}, 32'(mdc), 32'd0);
        check({tag, "_end_t"}, 32'(mdio_t), 32'd1);
        check({tag, "_end_ack"}, 32'(acc_en_ack), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mdc"}, 32'(mdc), 32'd0);
        check({tag, "_mdio_o"}, 32'(mdio_o), 32'd1);
        check({tag, "_mdio_t"}, 32'(mdio_t), 32'd1);
        check({tag, "_ack"}, 32'(acc_en_ack), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int          cyc;

        rst_n      = 1'b0;
        acc_en     = 1'b0;
        acc_data   = 32'h0;
        acc_en_s   = 1'b0;
        acc_data_s = 32'h0;
        phy_val    = 16'h0;
        rv_count   = 0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("post_reset");

        // Directed write and read frames.
        run_frame("write", 32'h5F8A_1234, 16'h0000, 0);
        run_frame("read", 32'h6000_0000, 16'hBEEF, 0);

        // Level hold across the end of the frame, then a second rise.
        d = $urandom;
        d[29] = 1'b0;
        run_frame("hold", d, 16'h0000, 300);
        d = $urandom;
        d[29] = 1'b1;
        run_frame("rerise", d, 16'($urandom), 0);

        // Randomized frames of either kind.
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            run_frame($sformatf("rand%0d", k), d, 16'($urandom), 0);
        end

        // Reset in the middle of the preamble of a read.
        obs_o.delete();
        obs_t.delete();
        rv_count = 0;
        phy_val  = 16'hFFFF;
        @(negedge clk);
        acc_data = 32'h6A5A_0000;
        acc_en   = 1'b1;
        cyc      = 0;
        while (obs_o.size() < 11 && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) acc_en = 1'b0;
        end
        acc_en = 1'b0;
        check("midrst_reached_bit10", 32'(obs_o.size()), 32'd11);
        #2 rst_n = 1'b0;
        #1;
        last_rd = 16'h0;
        check_reset_values("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_rd_valid", 32'(rv_count), 32'd0);
        d = $urandom;
        d[29] = 1'b1;
        run_frame("after_rst", d, 16'($urandom), 0);

        // MDC timing on the MDC_DIV=50 instance with a random write frame.
        min_iv      = 1000000;
        max_iv      = 0;
        rises_s     = 0;
        o_bad_s     = 0;
        busy_clks_s = 0;
        last_edge_s = -1;
        @(negedge clk);
        d = $urandom;
        d[29] = 1'b0;
        acc_data_s = d;
        acc_en_s   = 1'b1;
        cyc        = 0;
        while ((acc_en_s || busy_s) && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 4) acc_en_s = 1'b0;
        end
        acc_en_s = 1'b0;
        repeat (2) @(negedge clk);
        check("slow_busy_clks", 32'(busy_clks_s), 32'(65 * 2 * DIV_S));
        check("slow_mdc_rises", 32'(rises_s), 32'd65);
        check("slow_half_min", 32'(min_iv), 32'(DIV_S));
        check("slow_half_max", 32'(max_iv), 32'(DIV_S));
        check("slow_mdio_edges", 32'(o_bad_s), 32'd0);
        check("slow_end_mdc", 32'(mdc_s), 32'd0);
        check("slow_no_rd_valid", 32'(rd_valid_s), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 Parameter: MDC_DIV, default 50, meaning clk cycles per MDC half-period; legal range 2..255; 2.5 MHz MDC at 250 MHz clk.
REQ-002 Port: clk  in  1  sole clock; all logic on its rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: acc_data  in  32  MDIO frame: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD/DEVAD, [17:16] TA, [15:0] DATA.
REQ-005 Port: acc_en  in  1  request level; the producer holds it high until it sees acc_en_ack.
REQ-006 Port: acc_en_ack  out  1  request accepted; the producer samples it through two flops.
REQ-007 Port: mdc  out  1  MDIO management clock.
REQ-008 Port: mdio_o  out  1  MDIO data driven to the pad.
REQ-009 Port: mdio_t  out  1  pad tristate control; 1 = released (high-Z), 0 = driving.
REQ-010 Port: mdio_i  in  1  MDIO data read from the pad.
REQ-011 Port: rd_data  out  16  data captured by the last read frame.
REQ-012 Port: rd_valid  out  1  one-cycle pulse when rd_data updates.
REQ-013 Port: busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-014 FSM states: IDLE, PRE, FRAME, GAP. busy = (state != IDLE).
REQ-015 IDLE -> PRE when acc_en=1 and acc_en_ack=0: same edge latches acc_data into frame_sr and sets acc_en_ack=1; the 8-bit half-period counter and 6-bit bit counter clear, mdc=0, mdio_t=0, mdio_o=1.
REQ-016 acc_en_ack stays 1 while acc_en=1; it clears on the edge after acc_en is sampled 0, in any state.
REQ-017 A new request is accepted only in IDLE with acc_en_ack=0; acc_en held high across the end of a frame does not start a second frame.
REQ-018 Bit timing: each bit lasts 2*MDC_DIV clks; mdc rises after MDC_DIV clks and falls after 2*MDC_DIV clks; the next bit is presented on mdio_o on the same edge mdc falls.
REQ-019 PRE: drives 32 ones, then enters FRAME.
REQ-020 FRAME: shifts frame_sr MSB-first, 32 bits.
REQ-021 Read frame: OP[1]=1 (acc_data[29]=1); write or address frame: OP[1]=0.
REQ-022 Read frame: mdio_t=1 from the start of frame bit 17 (TA) through the end of the frame.
REQ-023 Read frame: mdio_i is sampled on each mdc rising edge of frame bits 15..0 into a shift register, MSB first.
REQ-024 Write frame: mdio_t=0 for all 32 frame bits.
REQ-025 After frame bit 0 the FSM enters GAP: mdio_t=1, mdio_o=1, one full MDC period of 2*MDC_DIV clks with mdc toggling, then IDLE with mdc=0.
REQ-026 Entering GAP from a read frame: rd_data updates and rd_valid pulses for exactly one cycle; write frames never assert rd_valid.
REQ-027 acc_en falling mid-frame has no effect on the frame in progress; the frame always completes from the latched copy.
REQ-028 Counters never wrap mid-frame; the bit counter covers 0..63 (32 preamble plus 32 frame).
REQ-029 Frame latency, accept to IDLE: 65*2*MDC_DIV clks, +1 clk for the state register.

Reset
REQ-030 rst_n=0 asynchronously forces: state=IDLE, mdc=0, mdio_o=1, mdio_t=1, acc_en_ack=0, busy=0, rd_data=0, rd_valid=0, all counters 0.
REQ-031 Reset asserted mid-frame aborts the frame immediately, with no rd_valid.
REQ-032 After rst_n rises, the block accepts the first request only once the cycle-after-reset edge has completed.

Verification (MDC_DIV=2 unless stated)
REQ-033 Write: acc_data=0x5F8A_1234 (ST=01, OP=01), acc_en held until ack seen through 2 flops -> ack 1 clk after acc_en; 32 ones then bits 0x5F8A1234 MSB-first on mdc rising edges; mdio_t=0 throughout; no rd_valid; busy low after 261 clks.
REQ-034 Read: acc_data=0x6000_0000 (OP=10), PHY model drives 0xBEEF from TA onward -> mdio_t=1 from frame bit 17; rd_data=0xBEEF; rd_valid pulses once.
REQ-035 Level hold: acc_en held high for 300 clks -> exactly one frame; ack drops 1 clk after acc_en falls; a second rise of acc_en starts a new frame.
REQ-036 Mid-frame reset: rst_n pulsed low at preamble bit 10 -> outputs take reset values at once; no rd_valid; the next request yields a complete frame.
REQ-037 Timing: MDC_DIV=50 -> mdc period 100 clks with 50% duty; mdio_o transitions only on mdc falling edges; total busy time 6500 clks ±1.
